// File: rtl/data_mem_hs.sv
// RV32IM data memory with valid/ready request and response handshakes and fault reporting.
// Latency: LATENCY edges from accept to op_resp_valid; response held until ip_resp_ready, one access in flight.
module data_mem_hs #(
    parameter logic [31:0] ADDR_BASE   = 32'h0200_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1
) (
    input  logic        ip_clk,
    input  logic        ip_rst,
    input  logic        ip_req_valid,
    output logic        op_req_ready,
    input  logic [31:0] ip_addr,
    input  logic [31:0] ip_store_data,
    input  logic [1:0]  ip_load_store_bit_ctrl,
    input  logic        ip_load_sign_ctrl,
    input  logic        ip_store_en,
    output logic        op_resp_valid,
    input  logic        ip_resp_ready,
    output logic [31:0] op_read_data,
    output logic [1:0]  op_fault
);
    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_END = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state, state_nxt;
    logic [3:0]         cnt, cnt_nxt;
    logic [31:0]        req_addr, req_data;
    logic [1:0]         req_size, req_fault;
    logic               req_sign, req_store;
    logic               accept, enter_resp;
    logic [31:0]        cur_addr, cur_data;
    logic [1:0]         cur_size, cur_fault;
    logic               cur_sign, cur_store;
    logic [IDX_W-1:0]   idx;
    logic [1:0]         lane;
    logic [31:0]        word_rd, load_val, wr_dat;
    logic [15:0]        word_sh;
    logic [3:0]         wr_be;
    logic [31:0]        mem [DEPTH_WORDS] = '{default: '0};

    function automatic logic [1:0] fault_of(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'b11)
            return 2'b11;
        if (a < ADDR_BASE || {1'b0, a} >= ADDR_END)
            return 2'b10;
        if ((sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00))
            return 2'b01;
        return 2'b00;
    endfunction

    assign op_req_ready  = (state == IDLE) && !ip_rst;
    assign op_resp_valid = (state == RESP);
    assign accept        = ip_req_valid && op_req_ready;

    // With LATENCY==1 the RAM is touched on the accept edge, before the request registers load.
    always_comb begin
        cur_addr  = req_addr;
        cur_data  = req_data;
        cur_size  = req_size;
        cur_sign  = req_sign;
        cur_store = req_store;
        cur_fault = req_fault;
        if (state == IDLE) begin
            cur_addr  = ip_addr;
            cur_data  = ip_store_data;
            cur_size  = ip_load_store_bit_ctrl;
            cur_sign  = ip_load_sign_ctrl;
            cur_store = ip_store_en;
            cur_fault = fault_of(ip_addr, ip_load_store_bit_ctrl);
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt  = RESP;
                    enter_resp = !ip_rst;
                end
            end
            RESP: begin
                if (ip_resp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        idx     = IDX_W'((cur_addr - ADDR_BASE) >> 2);
        lane    = cur_addr[1:0];
        word_rd = mem[idx];
        word_sh = 16'(word_rd >> {lane, 3'b000});
        wr_dat  = cur_data << {lane, 3'b000};
        case (cur_size)
            2'b00: begin
                load_val = {{24{word_sh[7] & ~cur_sign}}, word_sh[7:0]};
                wr_be    = 4'b0001 << lane;
            end
            2'b01: begin
                load_val = {{16{word_sh[15] & ~cur_sign}}, word_sh};
                wr_be    = 4'b0011 << lane;
            end
            2'b10: begin
                load_val = word_rd;
                wr_be    = 4'b1111;
            end
            default: begin
                load_val = 32'h0;
                wr_be    = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge ip_clk or posedge ip_rst) begin
        if (ip_rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            req_addr     <= 32'h0;
            req_data     <= 32'h0;
            req_size     <= 2'b00;
            req_sign     <= 1'b0;
            req_store    <= 1'b0;
            req_fault    <= 2'b00;
            op_read_data <= 32'h0;
            op_fault     <= 2'b00;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                req_addr  <= ip_addr;
                req_data  <= ip_store_data;
                req_size  <= ip_load_store_bit_ctrl;
                req_sign  <= ip_load_sign_ctrl;
                req_store <= ip_store_en;
                req_fault <= cur_fault;
            end
            if (enter_resp) begin
                op_fault     <= cur_fault;
                op_read_data <= (cur_store || cur_fault != 2'b00) ? 32'h0 : load_val;
            end
        end
    end

    // RAM contents survive reset; enter_resp is already suppressed while reset is asserted.
    always_ff @(posedge ip_clk) begin
        if (enter_resp && cur_store && cur_fault == 2'b00) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_be[k])
                    mem[idx][8*k +: 8] <= wr_dat[8*k +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_hs.sv
// Bench for data_mem_hs: instance 0 runs LATENCY=1, instance 1 runs LATENCY=3, sharing request fields.
module tb_data_mem_hs;
    logic        ip_clk_tb;
    logic        rst        [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] rdata      [2];
    logic [1:0]  fault      [2];
    logic [31:0] addr, wdata;
    logic [1:0]  size;
    logic        sign, store;
    int          checks = 0;
    int          fails  = 0;

    data_mem_hs #(.ADDR_BASE(32'h0200_0000), .DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .ip_clk(ip_clk_tb), .ip_rst(rst[0]), .ip_req_valid(req_valid[0]), .op_req_ready(req_ready[0]),
        .ip_addr(addr), .ip_store_data(wdata), .ip_load_store_bit_ctrl(size),
        .ip_load_sign_ctrl(sign), .ip_store_en(store), .op_resp_valid(resp_valid[0]),
        .ip_resp_ready(resp_ready[0]), .op_read_data(rdata[0]), .op_fault(fault[0]));

    data_mem_hs #(.ADDR_BASE(32'h0200_0000), .DEPTH_WORDS(1024), .LATENCY(3)) dut3 (
        .ip_clk(ip_clk_tb), .ip_rst(rst[1]), .ip_req_valid(req_valid[1]), .op_req_ready(req_ready[1]),
        .ip_addr(addr), .ip_store_data(wdata), .ip_load_store_bit_ctrl(size),
        .ip_load_sign_ctrl(sign), .ip_store_en(store), .op_resp_valid(resp_valid[1]),
        .ip_resp_ready(resp_ready[1]), .op_read_data(rdata[1]), .op_fault(fault[1]));

    initial ip_clk_tb = 1'b0;
    always #5 ip_clk_tb = ~ip_clk_tb;

    // Issue one request, measure accept-to-valid edges, then take the response.
    task automatic access(input int sel, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] sz, input logic sg, input logic st,
                          output logic [31:0] rd, output logic [1:0] ft, output int lat);
        int guard = 0;
        while (req_ready[sel] !== 1'b1 && guard < 20) begin
            @(negedge ip_clk_tb);
            guard++;
        end
        addr = a; wdata = d; size = sz; sign = sg; store = st;
        req_valid[sel] = 1'b1;
        @(posedge ip_clk_tb);
        #1 req_valid[sel] = 1'b0;
        lat = 0;
        do begin
            lat++;
            @(negedge ip_clk_tb);
        end while (resp_valid[sel] !== 1'b1 && lat < 20);
        if (resp_valid[sel] !== 1'b1) begin
            $display("FAIL resp_timeout: dut %0d addr %h valid %b required 1", sel, a, resp_valid[sel]);
            fails++;
        end
        checks++;
        rd = rdata[sel];
        ft = fault[sel];
        resp_ready[sel] = 1'b1;
        @(posedge ip_clk_tb);
        #1 resp_ready[sel] = 1'b0;
    endtask

    task automatic test_reset();
        rst[0] = 1'b1; rst[1] = 1'b1;
        repeat (3) @(negedge ip_clk_tb);
        for (int s = 0; s < 2; s++) begin
            if ({req_ready[s], resp_valid[s], rdata[s], fault[s]} !== 36'h0) begin
                $display("FAIL reset_state: dut %0d rdy %b vld %b data %h fault %b required all 0",
                         s, req_ready[s], resp_valid[s], rdata[s], fault[s]);
                fails++;
            end
            checks++;
        end
        @(posedge ip_clk_tb);
        #1 rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge ip_clk_tb);
        for (int s = 0; s < 2; s++) begin
            if (req_ready[s] !== 1'b1) begin
                $display("FAIL ready_after_reset: dut %0d rdy %b required 1", s, req_ready[s]);
                fails++;
            end
            checks++;
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic [1:0] ft; int lat;
        access(0, 32'h0200_0000, 32'h0, 2'b10, 1'b0, 1'b1, rd, ft, lat);
        access(0, 32'h0200_0000, 32'h08EF_965D, 2'b00, 1'b0, 1'b1, rd, ft, lat);
        if ({rd, ft} !== {32'h0, 2'b00}) begin
            $display("FAIL sb_resp: got %h/%b required 00000000/00", rd, ft); fails++;
        end
        checks++;
        access(0, 32'h0200_0000, 32'h0, 2'b10, 1'b0, 1'b0, rd, ft, lat);
        if ({rd, ft} !== {32'h0000_005D, 2'b00}) begin
            $display("FAIL sb_lw: got %h/%b required 0000005d/00", rd, ft); fails++;
        end
        checks++;
    endtask

    task automatic test_half();
        logic [31:0] rd; logic [1:0] ft; int lat;
        access(0, 32'h0200_000C, 32'h0, 2'b10, 1'b0, 1'b1, rd, ft, lat);
        access(0, 32'h0200_000E, 32'h5ED7_C51F, 2'b01, 1'b0, 1'b1, rd, ft, lat);
        access(0, 32'h0200_000E, 32'h0, 2'b01, 1'b0, 1'b0, rd, ft, lat);
        if ({rd, ft} !== {32'hFFFF_C51F, 2'b00}) begin
            $display("FAIL lh: got %h/%b required ffffc51f/00", rd, ft); fails++;
        end
        checks++;
        access(0, 32'h0200_000E, 32'h0, 2'b01, 1'b1, 1'b0, rd, ft, lat);
        if ({rd, ft} !== {32'h0000_C51F, 2'b00}) begin
            $display("FAIL lhu: got %h/%b required 0000c51f/00", rd, ft); fails++;
        end
        checks++;
        access(0, 32'h0200_000C, 32'h0, 2'b10, 1'b0, 1'b0, rd, ft, lat);
        if ({rd, ft} !== {32'hC51F_0000, 2'b00}) begin
            $display("FAIL sh_lw: got %h/%b required c51f0000/00", rd, ft); fails++;
        end
        checks++;
    endtask

    task automatic test_word_latency();
        logic [31:0] rd; logic [1:0] ft; int lat, exp_lat;
        for (int s = 0; s < 2; s++) begin
            exp_lat = (s == 0) ? 1 : 3;
            access(s, 32'h0200_0014, 32'h8765_4321, 2'b10, 1'b0, 1'b1, rd, ft, lat);
            if (lat != exp_lat) begin
                $display("FAIL store_latency: dut %0d got %0d edges required %0d", s, lat, exp_lat); fails++;
            end
            checks++;
            access(s, 32'h0200_0017, 32'h0, 2'b00, 1'b0, 1'b0, rd, ft, lat);
            if ({rd, ft} !== {32'hFFFF_FF87, 2'b00}) begin
                $display("FAIL lb: dut %0d got %h/%b required ffffff87/00", s, rd, ft); fails++;
            end
            checks++;
            access(s, 32'h0200_0017, 32'h0, 2'b00, 1'b1, 1'b0, rd, ft, lat);
            if ({rd, ft} !== {32'h0000_0087, 2'b00}) begin
                $display("FAIL lbu: dut %0d got %h/%b required 00000087/00", s, rd, ft); fails++;
            end
            checks++;
            access(s, 32'h0200_0014, 32'h0, 2'b10, 1'b1, 1'b0, rd, ft, lat);
            if ({rd, ft} !== {32'h8765_4321, 2'b00} || lat != exp_lat) begin
                $display("FAIL lw_latency: dut %0d got %h/%b lat %0d required 87654321/00 lat %0d",
                         s, rd, ft, lat, exp_lat); fails++;
            end
            checks++;
        end
    endtask

    task automatic test_faults();
        logic [31:0] rd; logic [1:0] ft; int lat;
        access(0, 32'h0200_0010, 32'h1122_3344, 2'b10, 1'b0, 1'b1, rd, ft, lat);
        access(0, 32'h0200_0012, 32'h0, 2'b10, 1'b0, 1'b0, rd, ft, lat);
        if ({rd, ft} !== {32'h0, 2'b01}) begin
            $display("FAIL misaligned_lw: got %h/%b required 00000000/01", rd, ft); fails++;
        end
        checks++;
        access(0, 32'h0200_0012, 32'hFFFF_FFFF, 2'b10, 1'b0, 1'b1, rd, ft, lat);
        if ({rd, ft} !== {32'h0, 2'b01}) begin
            $display("FAIL misaligned_sw: got %h/%b required 00000000/01", rd, ft); fails++;
        end
        checks++;
        access(0, 32'h0200_0010, 32'h0, 2'b10, 1'b0, 1'b0, rd, ft, lat);
        if ({rd, ft} !== {32'h1122_3344, 2'b00}) begin
            $display("FAIL misaligned_no_write: got %h/%b required 11223344/00", rd, ft); fails++;
        end
        checks++;
        access(0, 32'h0200_0010, 32'h0, 2'b11, 1'b0, 1'b0, rd, ft, lat);
        if ({rd, ft} !== {32'h0, 2'b11}) begin
            $display("FAIL illegal_size: got %h/%b required 00000000/11", rd, ft); fails++;
        end
        checks++;
        access(0, 32'h01FF_FFFC, 32'h0, 2'b10, 1'b0, 1'b0, rd, ft, lat);
        if ({rd, ft} !== {32'h0, 2'b10}) begin
            $display("FAIL below_base: got %h/%b required 00000000/10", rd, ft); fails++;
        end
        checks++;
        access(0, 32'h0200_1000, 32'h0, 2'b10, 1'b0, 1'b0, rd, ft, lat);
        if ({rd, ft} !== {32'h0, 2'b10}) begin
            $display("FAIL above_top: got %h/%b required 00000000/10", rd, ft); fails++;
        end
        checks++;
        access(0, 32'h0200_1000, 32'hFFFF_FFFF, 2'b10, 1'b0, 1'b1, rd, ft, lat);
        access(0, 32'h0200_0000, 32'h0, 2'b10, 1'b0, 1'b0, rd, ft, lat);
        if ({rd, ft} !== {32'h0000_005D, 2'b00}) begin
            $display("FAIL range_no_write: got %h/%b required 0000005d/00", rd, ft); fails++;
        end
        checks++;
    endtask

    task automatic test_backpressure();
        int guard = 0;
        addr = 32'h0200_0014; wdata = 32'h0; size = 2'b10; sign = 1'b0; store = 1'b0;
        req_valid[0] = 1'b1;
        @(posedge ip_clk_tb);
        #1 req_valid[0] = 1'b0;
        @(negedge ip_clk_tb);
        repeat (5) begin
            if ({resp_valid[0], req_ready[0], rdata[0], fault[0]} !== {1'b1, 1'b0, 32'h8765_4321, 2'b00}) begin
                $display("FAIL hold: vld %b rdy %b data %h fault %b required 1/0/87654321/00",
                         resp_valid[0], req_ready[0], rdata[0], fault[0]); fails++;
            end
            checks++;
            @(negedge ip_clk_tb);
        end
        resp_ready[0] = 1'b1;
        @(posedge ip_clk_tb);
        #1 resp_ready[0] = 1'b0;
        while (guard < 1) begin
            @(negedge ip_clk_tb);
            guard++;
        end
        if ({resp_valid[0], req_ready[0]} !== 2'b01) begin
            $display("FAIL release: vld %b rdy %b required 0/1", resp_valid[0], req_ready[0]); fails++;
        end
        checks++;
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic [1:0] ft; int lat;
        access(1, 32'h0200_0020, 32'h0, 2'b10, 1'b0, 1'b1, rd, ft, lat);
        addr = 32'h0200_0020; wdata = 32'hDEAD_BEEF; size = 2'b10; sign = 1'b0; store = 1'b1;
        req_valid[1] = 1'b1;
        @(posedge ip_clk_tb);
        #1 req_valid[1] = 1'b0;
        @(negedge ip_clk_tb);
        rst[1] = 1'b1;
        repeat (3) begin
            @(negedge ip_clk_tb);
            if ({resp_valid[1], req_ready[1]} !== 2'b00) begin
                $display("FAIL abort_quiet: vld %b rdy %b required 0/0", resp_valid[1], req_ready[1]); fails++;
            end
            checks++;
        end
        @(posedge ip_clk_tb);
        #1 rst[1] = 1'b0;
        access(1, 32'h0200_0020, 32'h0, 2'b10, 1'b0, 1'b0, rd, ft, lat);
        if ({rd, ft} !== {32'h0, 2'b00}) begin
            $display("FAIL abort_no_commit: got %h/%b required 00000000/00", rd, ft); fails++;
        end
        checks++;
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0;
            resp_ready[s] = 1'b0;
        end
        addr = 32'h0; wdata = 32'h0; size = 2'b00; sign = 1'b0; store = 1'b0;
        test_reset();
        test_byte();
        test_half();
        test_word_latency();
        test_faults();
        test_backpressure();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
